// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES encryption SPI master and its shifter:
//   state_t             - master FSM states
//   WAIT_CYCLES_DEFAULT - slave cipher latency in clocks
//   BLOCK_W             - AES block width in bits
//   CNT_W               - width of the master's transfer cycle counter
//   stream_len()        - number of bits sent to the slave for a given Nk
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_KEY,
        SEND_TEXT,
        WAIT,
        RECV,
        DONE
    } state_t;

    localparam int WAIT_CYCLES_DEFAULT = 54;
    localparam int BLOCK_W             = 128;
    localparam int CNT_W               = 10;

    // Outbound stream is the whole key followed by one plaintext block.
    function automatic int stream_len(input int nk);
        return 32 * nk + BLOCK_W;
    endfunction

endpackage

// File: rtl/aes_spi_shifter.sv
// -----------------------------------------------------------------------------
// aes_spi_shifter
// Serial datapath of the AES SPI master.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture load_data and present its MSB on mosi
//   shift      : present the next stored bit on mosi
//   load_data  : parallel word to transmit, MSB first
//   mosi       : registered serial output; 0 whenever neither load nor shift
//   capture    : shift miso into the receive register
//   miso       : serial input from the slave
//   rx_word    : received word, first bit in the MSB; the newest bit is taken
//                straight from miso so a complete block is available on the
//                very edge that samples its last bit
// -----------------------------------------------------------------------------
module aes_spi_shifter
    import aes_pkg::*;
#(
    parameter int TX_W = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic [TX_W-1:0]    load_data,
    output logic               mosi,
    input  logic               capture,
    input  logic               miso,
    output logic [BLOCK_W-1:0] rx_word
);

    logic [TX_W-1:0]    tx_sr;
    logic [BLOCK_W-2:0] rx_sr;

    // NOTE: sequential state is assigned with <= so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shift registers are plain flops, so clearing them on
            // reset is cheap and keeps stale key material off the outputs.
            tx_sr <= '0;
            rx_sr <= '0;
            mosi  <= 1'b0;
        end else begin
            if (load) begin
                mosi  <= load_data[TX_W-1];
                tx_sr <= {load_data[TX_W-2:0], 1'b0};
            end else if (shift) begin
                mosi  <= tx_sr[TX_W-1];
                tx_sr <= {tx_sr[TX_W-2:0], 1'b0};
            end else begin
                mosi  <= 1'b0;
            end

            if (capture) begin
                rx_sr <= {rx_sr[BLOCK_W-3:0], miso};
            end
        end
    end

    assign rx_word = {rx_sr, miso};

endmodule

// File: rtl/aes_encryption_master.sv
// -----------------------------------------------------------------------------
// aes_encryption_master
// SPI master that streams an AES key and one plaintext block to an external
// encryption slave, waits out the slave's cipher latency and reads back the
// ciphertext.
//   clk        : single clock, all outputs registered on posedge
//   reset      : synchronous active-high reset
//   start      : transfer request, only looked at in IDLE
//   key        : 32*Nk-bit key, MSB sent first, captured on acceptance
//   plaintext  : 128-bit block, MSB sent first, captured on acceptance
//   busy       : high from the cycle after acceptance through the DONE cycle
//   done       : one-cycle pulse, ciphertext valid
//   ciphertext : received block, first received bit in the MSB; held until
//                the next done or reset
//   cs         : active-low chip select
//   mosi       : serial data to slave (slave samples on posedge)
//   miso       : serial data from slave (slave drives on negedge)
// cnt holds n during the cycle after edge P(n), P0 being the accepting edge,
// so each FSM boundary is a compare against a fixed stream index.
// -----------------------------------------------------------------------------
module aes_encryption_master
    import aes_pkg::*;
#(
    parameter int Nk          = 4,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [32*Nk-1:0]   key,
    input  logic [BLOCK_W-1:0] plaintext,
    output logic               busy,
    output logic               done,
    output logic [BLOCK_W-1:0] ciphertext,
    output logic               cs,
    output logic               mosi,
    input  logic               miso
);

    localparam int KEY_W = 32 * Nk;
    localparam int LEN   = stream_len(Nk);

    // Value of cnt in the cycle before the edge that leaves each state.
    localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] TEXT_LAST = CNT_W'(LEN - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LEN + WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECV_LAST = CNT_W'(LEN + WAIT_CYCLES + BLOCK_W - 1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic               load;
    logic               shift;
    logic               capture;
    logic               last_bit;
    logic               busy_next;
    logic               done_next;
    logic               cs_next;
    logic [BLOCK_W-1:0] rx_word;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        // NOTE: the default assignment up front means every path assigns
        // next_state, so no latch is inferred.
        next_state = state;
        case (state)
            IDLE:      if (start) next_state = SEND_KEY;
            SEND_KEY:  if (cnt == KEY_LAST) next_state = SEND_TEXT;
            SEND_TEXT: if (cnt == TEXT_LAST) next_state = (WAIT_CYCLES == 0) ? RECV : WAIT;
            WAIT:      if (cnt == WAIT_LAST) next_state = RECV;
            RECV:      if (cnt == RECV_LAST) next_state = DONE;
            DONE:      next_state = IDLE;   // start is deliberately ignored here
            default:   next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        load      = (state == IDLE) && start;
        // The edge that leaves SEND_TEXT must not shift, so mosi drops to 0.
        shift     = (state == SEND_KEY) || ((state == SEND_TEXT) && (cnt != TEXT_LAST));
        capture   = (state == RECV);
        last_bit  = (state == RECV) && (cnt == RECV_LAST);
        busy_next = (next_state != IDLE);
        done_next = (next_state == DONE);
        cs_next   = (next_state == IDLE) || (next_state == DONE);
    end

    // ------------------------------------------------- registered datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cs         <= 1'b1;
            ciphertext <= '0;
        end else begin
            busy <= busy_next;
            done <= done_next;
            cs   <= cs_next;

            if (load) begin
                cnt <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
            end

            if (last_bit) begin
                ciphertext <= rx_word;
            end
        end
    end

    aes_spi_shifter #(
        .TX_W (LEN)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .shift     (shift),
        .load_data ({key, plaintext}),
        .mosi      (mosi),
        .capture   (capture),
        .miso      (miso),
        .rx_word   (rx_word)
    );

endmodule

// File: tb/tb_aes_encryption_master.sv
// -----------------------------------------------------------------------------
// tb_aes_encryption_master
// Two masters (Nk=4 and Nk=8) share clock and reset; each is wired to a
// behavioural slave that records the key/plaintext stream it receives and
// answers with a ciphertext: the FIPS-197 result for the FIPS-197 vectors,
// otherwise a simple keyed scramble of the block it actually received.
// -----------------------------------------------------------------------------
module tb_aes_encryption_master;

    localparam int W = 54;

    localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk;
    logic         reset;
    logic         start [2];
    logic [255:0] key   [2];
    logic [127:0] pt    [2];
    logic         busy  [2];
    logic         done  [2];
    logic [127:0] ct    [2];
    logic         cs    [2];
    logic         mosi  [2];

    int checks;
    int failures;
    int accepts [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Slave behaviour: known-answer vectors, otherwise a keyed scramble.
    function automatic logic [127:0] slave_cipher(input int nk, input logic [255:0] k,
                                                  input logic [127:0] p);
        if (nk == 4 && k == {128'h0, K128} && p == PT) return CT128;
        if (nk == 8 && k == K256 && p == PT) return CT256;
        return {p[126:0], p[127]} ^ k[127:0] ^ k[255:128] ^ 128'h5a5a_5a5a_5a5a_5a5a_5a5a_5a5a_5a5a_5a5a;
    endfunction

    // ------------------------------------------------ DUTs + slave models
    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int NK  = (g == 0) ? 4 : 8;
        localparam int LEN = 32 * NK + 128;

        logic         miso;
        int           j;
        logic [255:0] rx_key;
        logic [127:0] rx_pt;
        logic [127:0] resp;
        logic         prev_done;
        int           done_cnt;

        aes_encryption_master #(
            .Nk          (NK),
            .WAIT_CYCLES (W)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start[g]),
            .key        (key[g][32*NK-1:0]),
            .plaintext  (pt[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .ciphertext (ct[g]),
            .cs         (cs[g]),
            .mosi       (mosi[g]),
            .miso       (miso)
        );

        initial begin
            j = 0; rx_key = '0; rx_pt = '0; resp = '0;
            prev_done = 1'b0; done_cnt = 0; miso = 1'b0;
        end

        // j counts cycles with cs low; the value seen at the negedge after
        // P(j) is what the slave would sample at P(j+1).
        always @(negedge clk) begin
            if (cs[g] !== 1'b0) begin
                j      = 0;
                rx_key = '0;
                miso   = 1'($urandom);
            end else begin
                if (j < 32 * NK)   rx_key[32*NK-1-j] = mosi[g];
                else if (j < LEN)  rx_pt[LEN-1-j]    = mosi[g];
                else               check("mosi_quiet", 128'(mosi[g]), 128'(0));
                if (j == LEN) resp = slave_cipher(NK, rx_key, rx_pt);
                if (j >= LEN + W && j < LEN + W + 128) miso = resp[LEN+W+127-j];
                else                                   miso = 1'($urandom);
                j++;
            end
        end

        // Protocol monitor.
        always @(negedge clk) begin
            if (reset === 1'b0) begin
                check("cs_frame", 128'(cs[g]), 128'(!(busy[g] && !done[g])));
                if (cs[g] === 1'b1) check("mosi_idle", 128'(mosi[g]), 128'(0));
                if (done[g] === 1'b1) begin
                    check("done_width", 128'(prev_done), 128'(0));
                    check("done_busy", 128'(busy[g]), 128'(1));
                    done_cnt++;
                end
                prev_done = done[g];
            end
        end
    end

    // Called right after a negedge with the DUT idle; returns at the negedge
    // after the DONE cycle, so a following call is accepted back-to-back.
    task automatic run_xfer(input int l, input logic [255:0] k, input logic [127:0] p,
                            input logic [127:0] exp_ct, input bit scramble, input bit poke);
        int len;
        int n;
        len = (l == 0) ? 256 : 384;
        start[l] = 1'b1;
        key[l]   = k;
        pt[l]    = p;
        @(negedge clk);
        check("accept_busy", 128'(busy[l]), 128'(1));
        check("accept_cs", 128'(cs[l]), 128'(0));
        start[l] = 1'b0;
        if (scramble) begin
            key[l] = {rand128(), rand128()};
            pt[l]  = rand128();
        end
        n = 0;
        while (done[l] !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
            if (poke) start[l] = (n == len + 20);
        end
        start[l] = 1'b0;
        check("done_seen", 128'(done[l]), 128'(1));
        check("done_cycle", 128'(n), 128'(len + W + 128));
        check("ciphertext", ct[l], exp_ct);
        @(negedge clk);
        check("post_done", 128'(done[l]), 128'(0));
        check("post_busy", 128'(busy[l]), 128'(0));
        check("post_cs", 128'(cs[l]), 128'(1));
        accepts[l]++;
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        logic [255:0] k1, k2;
        logic [127:0] p1, p2;
        int n;

        checks = 0; failures = 0; accepts[0] = 0; accepts[1] = 0;
        reset = 1'b1;
        for (int l = 0; l < 2; l++) begin
            start[l] = 1'b0; key[l] = '0; pt[l] = '0;
        end
        repeat (3) @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            check("rst_cs", 128'(cs[l]), 128'(1));
            check("rst_busy", 128'(busy[l]), 128'(0));
            check("rst_done", 128'(done[l]), 128'(0));
            check("rst_mosi", 128'(mosi[l]), 128'(0));
            check("rst_ct", ct[l], 128'(0));
        end
        reset = 1'b0;

        // Known-answer transfers; the first start lands on the first edge
        // after reset is released.
        run_xfer(0, {128'h0, K128}, PT, CT128, 1'b0, 1'b0);
        run_xfer(1, K256, PT, CT256, 1'b0, 1'b0);

        // Inputs scrambled after acceptance and a start pulse during WAIT.
        run_xfer(0, {128'h0, K128}, PT, CT128, 1'b1, 1'b1);

        // Random blocks.
        for (int i = 0; i < 3; i++) begin
            k1 = {128'h0, rand128()};
            p1 = rand128();
            run_xfer(0, k1, p1, slave_cipher(4, k1, p1), 1'b1, (i == 1));
        end
        k1 = {rand128(), rand128()};
        p1 = rand128();
        run_xfer(1, k1, p1, slave_cipher(8, k1, p1), 1'b1, 1'b0);

        // Reset in the middle of SEND_TEXT, with start held as well.
        start[0] = 1'b1; key[0] = {128'h0, K128}; pt[0] = PT;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (199) @(negedge clk);
        reset    = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        check("midrst_cs", 128'(cs[0]), 128'(1));
        check("midrst_busy", 128'(busy[0]), 128'(0));
        check("midrst_done", 128'(done[0]), 128'(0));
        check("midrst_mosi", 128'(mosi[0]), 128'(0));
        check("midrst_ct", ct[0], 128'(0));
        @(negedge clk);
        check("rst_prio_busy", 128'(busy[0]), 128'(0));
        check("rst_prio_cs", 128'(cs[0]), 128'(1));
        reset    = 1'b0;
        start[0] = 1'b0;
        run_xfer(0, {128'h0, K128}, PT, CT128, 1'b0, 1'b0);

        // Back-to-back transfers with start held high.
        k1 = {128'h0, rand128()}; p1 = rand128();
        k2 = {128'h0, rand128()}; p2 = rand128();
        start[0] = 1'b1; key[0] = k1; pt[0] = p1;
        @(negedge clk);
        check("b2b_accept", 128'(busy[0]), 128'(1));
        n = 0;
        while (done[0] !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done1_cycle", 128'(n), 128'(256 + W + 128));
        check("b2b_ct1", ct[0], slave_cipher(4, k1, p1));
        key[0] = k2; pt[0] = p2;
        @(negedge clk);
        check("b2b_gap_cs", 128'(cs[0]), 128'(1));
        check("b2b_gap_busy", 128'(busy[0]), 128'(0));
        @(negedge clk);
        check("b2b_restart_cs", 128'(cs[0]), 128'(0));
        check("b2b_restart_busy", 128'(busy[0]), 128'(1));
        start[0] = 1'b0;
        n = 0;
        while (done[0] !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done2_cycle", 128'(n), 128'(256 + W + 128));
        check("b2b_ct2", ct[0], slave_cipher(4, k2, p2));
        @(negedge clk);
        check("b2b_post_done", 128'(done[0]), 128'(0));
        accepts[0] += 2;

        repeat (4) @(negedge clk);
        check("done_count0", 128'(g_lane[0].done_cnt), 128'(accepts[0]));
        check("done_count1", 128'(g_lane[1].done_cnt), 128'(accepts[1]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_encryption_master.md
AES_ENCRYPTION_MASTER -- requirements
Module: aes_encryption_master

Interface
REQ-001 Parameter: Nk, default 4, key length in 32-bit words; legal values 4, 6, 8.
REQ-002 Parameter: WAIT_CYCLES, default 54, idle clocks between the last plaintext bit and the first ciphertext bit (slave cipher latency).
REQ-003 clk  input  1  single clock; all outputs registered on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 key  input  32*Nk  AES key, bit 0 (MSB) sent first; captured on accepted start.
REQ-007 plaintext  input  128  block to encrypt, bit 0 (MSB) sent first; captured on accepted start.
REQ-008 busy  output  1  high from the cycle after start is accepted until the DONE cycle, inclusive.
REQ-009 done  output  1  single-cycle pulse; ciphertext is valid.
REQ-010 ciphertext  output  128  received block, bit 0 (MSB) first on the wire; held until the next done or reset.
REQ-011 cs  output  1  active-low chip select to the AES encryption slave.
REQ-012 mosi  output  1  serial data to the slave; slave samples it on posedge clk.
REQ-013 miso  input  1  serial data from the slave; slave drives it on negedge clk; master samples it on posedge clk.

Function
REQ-014 FSM states: IDLE, SEND_KEY, SEND_TEXT, WAIT, RECV, DONE.
REQ-015 Let L = 32*Nk+128. A 10-bit cycle counter cnt counts posedges after acceptance (P0 = accepting edge).
REQ-016 IDLE with start=1 at P0: capture key and plaintext into a shift register, drive cs=0 and mosi=key[0], go to SEND_KEY.
REQ-017 SEND_KEY/SEND_TEXT: mosi presents stream bit n during the cycle after P(n); the slave samples bit n at P(n+1), n = 0..L-1; key bits first, then plaintext bits.
REQ-018 After the last plaintext bit is presented, go to WAIT; mosi=0 and cs=0 for WAIT_CYCLES clocks.
REQ-019 RECV: sample miso at P(L+WAIT_CYCLES+1+k) into ciphertext bit k, k = 0..127. Nk=4 gives bit 0 at P311 and bit 127 at P438.
REQ-020 At the edge that samples bit 127: drive cs=1, go to DONE; done=1 for exactly that one cycle; ciphertext updated on the same edge.
REQ-021 DONE always returns to IDLE; start during DONE is ignored. cs is high for at least 2 clocks between transfers.
REQ-022 start during busy is ignored; key and plaintext changes after acceptance do not affect the transfer.
REQ-023 cs stays continuously low from P0 through the RECV sampling of bit 127; no gaps.
REQ-024 mosi is 0 whenever cs=1 or the FSM is in WAIT/RECV.

Reset
REQ-025 reset=1 at any posedge, mid-transfer included: state=IDLE, cnt=0, cs=1, mosi=0, busy=0, done=0, ciphertext=0, shift register=0.
REQ-026 reset takes priority over start on the same edge.
REQ-027 The first start is accepted on the first edge with reset=0 and start=1.

Structure
REQ-028 A shared package (aes_pkg) holds the state enumeration, WAIT_CYCLES default, and the function computing L from Nk.
REQ-029 One sub-module, aes_spi_shifter: parallel-load PISO for mosi plus 128-bit SIPO for miso, with load/shift enables.
REQ-030 No other sub-modules; the FSM and counter live in aes_encryption_master.

Verification
REQ-031 Loopback to the AES encryption slave, Nk=4: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> done at P438, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-032 Nk=8 key 00..1f, same plaintext -> ciphertext 8ea2b7ca516745bfeafc49904b496089; done at P(256+128+54+128)=P566.
REQ-033 reset asserted at P200 mid-SEND_TEXT -> next cycle cs=1, busy=0, ciphertext=0; a new transfer then matches REQ-031.
REQ-034 start held high continuously -> back-to-back transfers; cs high exactly 2 clocks between them; each done single-cycle.
REQ-035 start pulse during WAIT; key changed after P0 -> no effect; ciphertext still matches REQ-031.
REQ-036 Protocol checker: cs never deasserts mid-transfer; mosi=0 whenever cs=1; exactly one done per accepted start.
